// File: rtl/ctl_shot.sv
// ctl_shot: shot/hit controller for the duck game.
// Turns left-button clicks into shots, tests each shot against the duck
// bounding box, and tracks bullets per duck and the player score.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   game_start            single-cycle start/restart pulse
//   mouse_left            left button level (already synchronous to clk)
//   mouse_x, mouse_y      cursor position (12 bits)
//   duck_x, duck_y        duck top-left corner (10 bits)
//   duck_show, duck_hit   duck visible / duck falling, from duck controller
//   hit, shot             one-cycle pulses: shot landed / any accepted shot
//   bullets               remaining bullets for the current duck
//   score                 ducks hit since game_start, saturating
//   out_of_ammo           magazine empty, game over

module ctl_shot #(
  parameter int unsigned DUCK_W   = 64,
  parameter int unsigned DUCK_H   = 64,
  parameter int unsigned MAG_SIZE = 3,
  parameter int unsigned SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_start,
  input  logic               mouse_left,
  input  logic [11:0]        mouse_x,
  input  logic [11:0]        mouse_y,
  input  logic [9:0]         duck_x,
  input  logic [9:0]         duck_y,
  input  logic               duck_show,
  input  logic               duck_hit,
  output logic               hit,
  output logic               shot,
  output logic [2:0]         bullets,
  output logic [SCORE_W-1:0] score,
  output logic               out_of_ammo
);

  localparam int unsigned CW = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_EVAL,
    S_FALLING,
    S_EMPTY
  } state_t;

  state_t             r_state;
  logic               r_mouse_left_q;
  logic [CW-1:0]      r_sx;
  logic [CW-1:0]      r_sy;
  logic               r_hit;
  logic               r_shot;
  logic [2:0]         r_bullets;
  logic [SCORE_W-1:0] r_score;
  logic               r_out_of_ammo;

  logic               w_click;
  logic [CW-1:0]      w_x_lo;
  logic [CW-1:0]      w_x_hi;
  logic [CW-1:0]      w_y_lo;
  logic [CW-1:0]      w_y_hi;
  logic               w_in_box;
  logic               w_can_fire;

  // Rising edge of the button: a held button yields a single click.
  assign w_click    = mouse_left & ~r_mouse_left_q;
  assign w_can_fire = w_click & duck_show & ~duck_hit;

  // Box edges widened to 12 bits so a duck near x=1023 does not wrap.
  assign w_x_lo   = CW'(duck_x);
  assign w_y_lo   = CW'(duck_y);
  assign w_x_hi   = CW'(duck_x) + CW'(DUCK_W - 1);
  assign w_y_hi   = CW'(duck_y) + CW'(DUCK_H - 1);
  assign w_in_box = (r_sx >= w_x_lo) && (r_sx <= w_x_hi) &&
                    (r_sy >= w_y_lo) && (r_sy <= w_y_hi);

  // Game FSM with registered outputs; game_start overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_mouse_left_q <= 1'b0;
      r_sx           <= '0;
      r_sy           <= '0;
      r_hit          <= 1'b0;
      r_shot         <= 1'b0;
      r_bullets      <= '0;
      r_score        <= '0;
      r_out_of_ammo  <= 1'b0;
    end else begin
      r_mouse_left_q <= mouse_left;
      r_hit          <= 1'b0;
      r_shot         <= 1'b0;

      if (game_start) begin
        // Restart discards any pending shot and any coincident click.
        r_state       <= S_ARMED;
        r_bullets     <= 3'(MAG_SIZE);
        r_score       <= '0;
        r_out_of_ammo <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end

          S_ARMED: begin
            if (w_can_fire) begin
              r_sx    <= mouse_x;
              r_sy    <= mouse_y;
              r_state <= S_EVAL;
            end
          end

          S_EVAL: begin
            r_shot <= 1'b1;
            if (w_in_box) begin
              r_hit   <= 1'b1;
              r_score <= (r_score == {SCORE_W{1'b1}}) ? r_score
                                                      : r_score + SCORE_W'(1);
              r_state <= S_FALLING;
            end else begin
              r_bullets <= r_bullets - 3'd1;
              if (r_bullets == 3'd1) begin
                r_out_of_ammo <= 1'b1;
                r_state       <= S_EMPTY;
              end else begin
                r_state <= S_ARMED;
              end
            end
          end

          S_FALLING: begin
            // Duck gone from screen: the next duck gets a full magazine.
            if (!duck_show) begin
              r_bullets <= 3'(MAG_SIZE);
              r_state   <= S_ARMED;
            end
          end

          S_EMPTY: begin
            r_state <= S_EMPTY;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign hit         = r_hit;
  assign shot        = r_shot;
  assign bullets     = r_bullets;
  assign score       = r_score;
  assign out_of_ammo = r_out_of_ammo;

endmodule

// File: doc/ctl_shot.md
Name: ctl_shot

Overview:
- Shot/hit controller that sits directly upstream of the duck position controller and drives its `hit` input.
- Turns mouse left-button clicks into shots and checks each shot against the duck bounding box built from `duck_x`/`duck_y`.
- Tracks remaining bullets per duck and the player score.
- Consumes `duck_x`, `duck_y`, `duck_show` and `duck_hit` back from the duck controller, closing the game loop.

Parameters:
- DUCK_W, 64, duck sprite width in pixels (bounding box x extent).
- DUCK_H, 64, duck sprite height in pixels (bounding box y extent).
- MAG_SIZE, 3, bullets available per duck; legal range 1..7.
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- game_start  in  1  single-cycle start/restart pulse.
- mouse_left  in  1  left button level, already synchronous to clk.
- mouse_x  in  12  cursor x.
- mouse_y  in  12  cursor y.
- duck_x  in  10  duck top-left x.
- duck_y  in  10  duck top-left y.
- duck_show  in  1  duck visible and flying or falling.
- duck_hit  in  1  duck in falling state.
- hit  out  1  one-cycle pulse when a shot lands on the duck.
- shot  out  1  one-cycle pulse for every accepted shot, hit or miss.
- bullets  out  3  remaining bullets.
- score  out  SCORE_W  ducks hit since game_start, saturating.
- out_of_ammo  out  1  level; magazine empty, game over.

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk. All outputs 0, state IDLE, the click edge register cleared.
- Click edge: `click = mouse_left & ~mouse_left_q`, where `mouse_left_q` is registered every cycle (cleared by rst). Holding the button produces exactly one click.
- States: IDLE, ARMED, EVAL, FALLING, EMPTY.
- IDLE: ignores clicks. On game_start → ARMED, bullets=MAG_SIZE, score=0.
- ARMED:
  - On click with duck_show=1 and duck_hit=0: latch mouse_x/mouse_y into shot registers → EVAL.
  - Clicks with duck_show=0 or duck_hit=1 are ignored; no bullet is spent.
- EVAL (one cycle): compare the latched coordinates against the current duck_x/duck_y.
  - Inside box means `duck_x ≤ sx ≤ duck_x+DUCK_W-1` AND `duck_y ≤ sy ≤ duck_y+DUCK_H-1`.
  - Box edges are computed zero-extended to 12 bits, so there is no wrap near 1023.
  - Registered results appear in the cycle after EVAL:
    - shot=1 always.
    - Hit: hit=1, score+1 (saturating at all-ones), bullets unchanged → FALLING.
    - Miss: bullets−1. If the new bullets=0 → EMPTY, else → ARMED.
- Latency: first cycle mouse_left=1 is cycle N. EVAL is cycle N+1. hit/shot/bullets/score are updated and visible in cycle N+2.
- FALLING: clicks ignored. When duck_show=0 (duck has landed and a new duck is being drawn): bullets=MAG_SIZE → ARMED.
- EMPTY: out_of_ammo=1 (registered; asserted together with bullets becoming 0). Clicks ignored. Leaves only on game_start.
- game_start from any state, including mid-EVAL:
  - → ARMED, bullets=MAG_SIZE, score=0, out_of_ammo=0, no hit/shot pulse.
  - game_start wins over a coincident click; that click is discarded.
- hit and shot are never high for more than one consecutive cycle.
- Holding mouse_left across game_start fires no shot until the button is released and pressed again.
- rst mid-operation returns to IDLE within one cycle; any pending EVAL result is discarded.

Test Plan:
- Reset, game_start, duck_x=100, duck_y=200, duck_show=1; click at (130,230) → hit=1 and shot=1 at N+2; score=1; bullets=3; state FALLING. Drop duck_show → bullets=3, back to ARMED.
- Boundary accuracy:
  - Clicks at (163,263) → hit (corner of box).
  - (164,230) → miss.
  - (99,230) → miss, bullets=2.
  - duck_x=1000, click x=1063 → hit (no 10-bit wrap).
- Three misses at (0,0) → bullets 3→2→1→0; out_of_ammo=1 with the third shot pulse. A further click produces no shot. game_start → bullets=3, score=0, out_of_ammo=0.
- Ignored clicks:
  - Button held 50 cycles → exactly one shot.
  - Click with duck_show=0 or duck_hit=1 → no shot, bullets unchanged.
  - Clicks in IDLE → nothing.
- game_start and click in the same cycle, and game_start during EVAL → no hit/shot pulse, bullets=MAG_SIZE, score=0.
- Score saturation with SCORE_W=2: four consecutive hits → score 1,2,3,3; hit still pulses on the fourth.
